// File: rtl/div_pkg.sv
// div_pkg: shared widths, request/response structs and dispatch state for the divider front-end
package div_pkg;
  localparam int DIV_W = 32;
  localparam int DIV_TAG_W = 4;
  typedef struct packed {
    logic sgn;
    logic [DIV_W-1:0] num;
    logic [DIV_W-1:0] den;
    logic [DIV_TAG_W-1:0] tag;
  } div_req_t;
  typedef struct packed {
    logic [DIV_TAG_W-1:0] tag;
    logic [DIV_W-1:0] quotient;
    logic [3:0] flags;
    logic err;
    logic timeout;
  } div_rsp_t;
  typedef enum logic {IDLE, WAIT} div_disp_state_e;
endpackage

// File: rtl/div_dispatch_if.sv
// div_dispatch_if: request port, divider issue/result port and response port of div_dispatch (slave = dispatcher side)
interface div_dispatch_if #(parameter int TAG_W = 4);
  import div_pkg::*;
  logic i_req_valid, o_req_ready, i_req_signed;
  logic [DIV_W-1:0] i_req_num, i_req_den;
  logic [TAG_W-1:0] i_req_tag;
  logic o_div_wr, o_div_signed;
  logic [DIV_W-1:0] o_div_num, o_div_den;
  logic i_div_busy, i_div_valid, i_div_err;
  logic [DIV_W-1:0] i_div_quotient;
  logic [3:0] i_div_flags;
  logic o_rsp_valid, i_rsp_ready;
  logic [TAG_W-1:0] o_rsp_tag;
  logic [DIV_W-1:0] o_rsp_quotient;
  logic [3:0] o_rsp_flags;
  logic o_rsp_err, o_rsp_timeout, o_idle;
  modport slave (
    input i_req_valid, i_req_signed, i_req_num, i_req_den, i_req_tag,
    input i_div_busy, i_div_valid, i_div_err, i_div_quotient, i_div_flags, i_rsp_ready,
    output o_req_ready, o_div_wr, o_div_signed, o_div_num, o_div_den,
    output o_rsp_valid, o_rsp_tag, o_rsp_quotient, o_rsp_flags, o_rsp_err, o_rsp_timeout, o_idle
  );
  modport master (
    output i_req_valid, i_req_signed, i_req_num, i_req_den, i_req_tag,
    output i_div_busy, i_div_valid, i_div_err, i_div_quotient, i_div_flags, i_rsp_ready,
    input o_req_ready, o_div_wr, o_div_signed, o_div_num, o_div_den,
    input o_rsp_valid, o_rsp_tag, o_rsp_quotient, o_rsp_flags, o_rsp_err, o_rsp_timeout, o_idle
  );
endinterface

// File: rtl/div_req_fifo.sv
// div_req_fifo: power-of-2 request FIFO (push/pop/din in, dout head, full/empty out), async active-low reset
module div_req_fifo import div_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  div_req_t din,
  output div_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  div_req_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/div_dispatch.sv
// div_dispatch: queues tagged divide requests (io.i_req_*), issues one at a time to the divider (io.o_div_*), returns tagged results or watchdog errors (io.o_rsp_*)
module div_dispatch import div_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int TAG_W = DIV_TAG_W,
  parameter int TIMEOUT = 64
) (
  input logic          i_clk,
  input logic          i_reset_n,
  div_dispatch_if.slave io
);
  localparam int WW = $clog2(TIMEOUT);
  div_disp_state_e state, state_nx;
  div_req_t req_in, head, cur;
  div_rsp_t rsp;
  logic full, empty, issue, done, expire, rsp_valid, div_wr;
  logic [WW-1:0] wd;
  assign req_in = '{sgn: io.i_req_signed, num: io.i_req_num, den: io.i_req_den, tag: DIV_TAG_W'(io.i_req_tag)};
  div_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(i_clk), .rst_n(i_reset_n), .push(io.i_req_valid & !full), .pop(issue),
    .din(req_in), .dout(head), .full(full), .empty(empty)
  );
  always_comb begin
    issue = state == IDLE && !empty && !io.i_div_busy && (!rsp_valid || io.i_rsp_ready);
    done = state == WAIT && !div_wr && io.i_div_valid;
    expire = state == WAIT && !div_wr && !io.i_div_valid && wd == WW'(TIMEOUT - 1);
    state_nx = issue ? WAIT : (done || expire) ? IDLE : state;
  end
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      div_wr <= 1'b0;
      cur <= '0;
      wd <= '0;
      rsp <= '0;
      rsp_valid <= 1'b0;
    end else begin
      div_wr <= issue;
      if (issue) cur <= head;
      wd <= issue ? '0 : state == WAIT ? wd + WW'(1) : wd;
      if (done) rsp <= '{cur.tag, io.i_div_quotient, io.i_div_flags, io.i_div_err, 1'b0};
      else if (expire) rsp <= '{cur.tag, '0, 4'h0, 1'b1, 1'b1};
      rsp_valid <= done || expire || (rsp_valid && !io.i_rsp_ready);
    end
  assign io.o_req_ready = !full;
  assign io.o_div_wr = div_wr;
  assign io.o_div_signed = cur.sgn;
  assign io.o_div_num = cur.num;
  assign io.o_div_den = cur.den;
  assign io.o_rsp_valid = rsp_valid;
  assign io.o_rsp_tag = TAG_W'(rsp.tag);
  assign io.o_rsp_quotient = rsp.quotient;
  assign io.o_rsp_flags = rsp.flags;
  assign io.o_rsp_err = rsp.err;
  assign io.o_rsp_timeout = rsp.timeout;
  assign io.o_idle = empty && state == IDLE && !rsp_valid;
endmodule

// File: tb/tb_div_dispatch.sv
// tb_div_dispatch: directed scoreboard bench for div_dispatch with a behavioural 34-cycle divider
module tb_div_dispatch;
  import div_pkg::*;
  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 64, LAT = 34;
  typedef struct packed {logic sgn; logic [31:0] num; logic [31:0] den;} op_t;
  typedef struct packed {logic [3:0] tag; logic [31:0] q; logic [3:0] flags; logic err; logic tmo;} exp_t;
  logic clk = 0, rst_n, hang = 0, ext_busy = 0, spur = 0, m_busy, m_valid, prev_wr = 0;
  int n_chk = 0, n_pass = 0, wr_cnt = 0, cyc = 0, m_cnt;
  op_t m_op, mon_op;
  exp_t mon_rsp;
  op_t op_q[$];
  exp_t rsp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  div_dispatch_if #(.TAG_W(TAG_W)) io();
  div_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (.i_clk(clk), .i_reset_n(rst_n), .io(io.slave));
  function automatic logic [31:0] quo(logic s, logic [31:0] n, logic [31:0] d);
    logic signed [31:0] sq;
    if (d == 0) return '0;
    if (!s) return n / d;
    sq = $signed(n) / $signed(d);
    return sq;
  endfunction
  function automatic logic [3:0] fl(logic [31:0] q);
    return {2'b00, q[31], q == 32'd0};
  endfunction
  task automatic chk(string tag, logic [95:0] obs, logic [95:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_valid <= 1'b0;
      m_cnt <= 0;
      m_op <= '0;
    end else begin
      m_valid <= 1'b0;
      if (io.o_div_wr && !hang) begin
        m_busy <= 1'b1;
        m_cnt <= LAT;
        m_op <= '{io.o_div_signed, io.o_div_num, io.o_div_den};
      end else if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_valid <= 1'b1;
        m_cnt <= 0;
      end else if (m_cnt > 1) m_cnt <= m_cnt - 1;
    end
  assign io.i_div_busy = m_busy | ext_busy;
  assign io.i_div_valid = m_valid | spur;
  assign io.i_div_err = m_valid & (m_op.den == 0);
  assign io.i_div_quotient = m_valid ? quo(m_op.sgn, m_op.num, m_op.den) : '0;
  assign io.i_div_flags = m_valid ? fl(quo(m_op.sgn, m_op.num, m_op.den)) : '0;
  always @(negedge clk) begin
    if (io.o_div_wr) begin
      wr_cnt++;
      chk("wr_single_cycle", prev_wr, 0);
      chk("op_expected", op_q.size() > 0, 1);
      if (op_q.size() > 0) begin
        mon_op = op_q.pop_front();
        chk("div_signed", io.o_div_signed, mon_op.sgn);
        chk("div_num", io.o_div_num, mon_op.num);
        chk("div_den", io.o_div_den, mon_op.den);
      end
    end
    prev_wr = io.o_div_wr;
    if (io.o_rsp_valid && io.i_rsp_ready) begin
      chk("rsp_expected", rsp_q.size() > 0, 1);
      if (rsp_q.size() > 0) begin
        mon_rsp = rsp_q.pop_front();
        chk("rsp_tag", io.o_rsp_tag, mon_rsp.tag);
        chk("rsp_quotient", io.o_rsp_quotient, mon_rsp.q);
        chk("rsp_flags", io.o_rsp_flags, mon_rsp.flags);
        chk("rsp_err", io.o_rsp_err, mon_rsp.err);
        chk("rsp_timeout", io.o_rsp_timeout, mon_rsp.tmo);
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(logic s, logic [31:0] n, logic [31:0] d, logic [3:0] t, bit hung = 0, bit dropped = 0);
    int b = 0;
    logic [31:0] q;
    while (!io.o_req_ready && b < 500) begin
      tick();
      b++;
    end
    chk("req_ready_wait", io.o_req_ready, 1);
    io.i_req_valid = 1;
    io.i_req_signed = s;
    io.i_req_num = n;
    io.i_req_den = d;
    io.i_req_tag = t;
    tick();
    io.i_req_valid = 0;
    q = quo(s, n, d);
    op_q.push_back('{s, n, d});
    if (!dropped) rsp_q.push_back(hung ? exp_t'{t, 32'd0, 4'h0, 1'b1, 1'b1} : exp_t'{t, q, fl(q), d == 0, 1'b0});
  endtask
  task automatic wait_idle(int budget);
    int b = 0;
    while (!io.o_idle && b < budget) begin
      tick();
      b++;
    end
    chk("idle_reached", io.o_idle, 1);
    chk("sb_drained", rsp_q.size(), 0);
  endtask
  task automatic wait_sig(string tag, int budget, bit rsp);
    int b = 0;
    while (!(rsp ? io.o_rsp_valid : io.o_div_wr) && b < budget) begin
      tick();
      b++;
    end
    chk(tag, rsp ? io.o_rsp_valid : io.o_div_wr, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int w, c0;
    io.i_req_valid = 0;
    io.i_req_signed = 0;
    io.i_req_num = '0;
    io.i_req_den = '0;
    io.i_req_tag = '0;
    io.i_rsp_ready = 1;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    chk("rst_req_ready", io.o_req_ready, 1);
    chk("rst_idle", io.o_idle, 1);
    chk("rst_div_wr", io.o_div_wr, 0);
    chk("rst_rsp_valid", io.o_rsp_valid, 0);
    chk("rst_div_num", io.o_div_num, 0);
    chk("rst_rsp_quotient", io.o_rsp_quotient, 0);
    tick(2);
    rst_n = 1;
    tick();
    send(0, 100, 7, 3);
    wait_idle(200);
    ext_busy = 1;
    w = wr_cnt;
    for (int i = 0; i < 4; i++) send(0, 32'(1000 + 37 * i), 32'(i + 2), 4'(i));
    chk("full_not_ready", io.o_req_ready, 0);
    tick(5);
    chk("no_issue_busy", wr_cnt, w);
    ext_busy = 0;
    wait_idle(400);
    chk("one_wr_per_divide", wr_cnt - w, 4);
    send(1, -32'sd20, 3, 5);
    send(0, 5, 0, 6);
    wait_idle(200);
    io.i_rsp_ready = 0;
    send(0, 40, 8, 7);
    send(0, 33, 11, 8);
    wait_sig("first_rsp_valid", 200, 1);
    w = wr_cnt;
    for (int i = 0; i < 50; i++) begin
      chk("held_tag", io.o_rsp_tag, 7);
      chk("held_quotient", io.o_rsp_quotient, 5);
      tick();
    end
    chk("no_issue_while_held", wr_cnt, w);
    io.i_rsp_ready = 1;
    tick();
    chk("issue_on_release", io.o_div_wr, 1);
    wait_idle(200);
    hang = 1;
    send(0, 9, 3, 9, 1);
    wait_sig("hung_issue", 20, 0);
    c0 = cyc;
    wait_sig("timeout_rsp", 200, 1);
    chk("timeout_latency", cyc - c0, TIMEOUT);
    hang = 0;
    tick();
    spur = 1;
    tick();
    spur = 0;
    tick(3);
    chk("spurious_no_rsp", io.o_rsp_valid, 0);
    wait_idle(10);
    send(0, 50, 5, 10, 0, 1);
    wait_sig("reset_case_issue", 20, 0);
    tick(5);
    #2 rst_n = 0;
    #1;
    chk("async_rst_rsp_valid", io.o_rsp_valid, 0);
    chk("async_rst_idle", io.o_idle, 1);
    chk("async_rst_req_ready", io.o_req_ready, 1);
    chk("async_rst_div_num", io.o_div_num, 0);
    chk("async_rst_div_den", io.o_div_den, 0);
    tick(2);
    rst_n = 1;
    tick();
    send(0, 81, 9, 11);
    wait_idle(200);
    chk("op_q_drained", op_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
